// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receive FSM state encoding,
// data-width decode and parity-select encodings.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      START_BIT      = 3'd1,
      DATA           = 3'd2,
      PARITY         = 3'd3,
      STOP_BIT_FIRST = 3'd4,
      STOP_BIT_LAST  = 3'd5
   } state_t;

   localparam logic [1:0] PAR_ODD  = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ZERO = 2'b10;
   localparam logic [1:0] PAR_ONE  = 2'b11;

   // 00..11 selects 8..5 data bits -> last index 7..4
   function automatic logic [2:0] last_bit(
      input logic [1:0] bits
   );
      return 3'h7 - {1'b0, bits};
   endfunction

   // acc is the XOR of all data bits
   function automatic logic par_exp(
      input logic [1:0] sel,
      input logic       acc
   );
      logic e;
      e = 1'b1;
      unique case (sel)
         PAR_ODD:  e = ~acc;
         PAR_EVEN: e = acc;
         PAR_ZERO: e = 1'b0;
         PAR_ONE:  e = 1'b1;
         default:  e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
// Ports: clk, rst_n (async, low), d (async in), q (synced out); resets to 1.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing, one-entry holding register
// drained by valid/ready, one-cycle parity/frame/overrun error pulses.
module uart_rx
   import uart_rx_pkg::*;
(
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        rx_i,
   input  logic        cfg_en_i,
   input  logic [15:0] cfg_div_i,
   input  logic        cfg_parity_en_i,
   input  logic [1:0]  cfg_parity_sel_i,
   input  logic [1:0]  cfg_bits_i,
   input  logic        cfg_stop_bits_i,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic        busy_o,
   output logic        err_parity_o,
   output logic        err_frame_o,
   output logic        err_overrun_o
);

   logic        rx_s;
   state_t      state;
   logic [15:0] cnt;
   logic [15:0] target;
   logic [7:0]  sh;
   logic [2:0]  idx;
   logic        par_acc;
   logic        par_err;
   logic        sample;
   logic        frame_end;
   logic        keep;
   logic        load;
   logic        ovr;

   uart_rx_sync u_sync (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .d     (rx_i),
      .q     (rx_s)
   );

   // Start bit is sampled at mid-bit, everything later one full bit apart
   assign target = (state == START_BIT) ? (cfg_div_i >> 1) : cfg_div_i;

   // >= rather than == so a mid-frame divider change cannot stall the FSM
   assign sample = (state != IDLE) && (cnt >= target);

   assign busy_o = (state != IDLE);

   always_comb begin
      frame_end = 1'b0;
      if (cfg_en_i && sample) begin
         if (state == STOP_BIT_FIRST)
            frame_end = !(cfg_stop_bits_i && rx_s);
         if (state == STOP_BIT_LAST)
            frame_end = 1'b1;
      end
   end

   // rx_s is the stop bit being sampled at frame end
   assign keep = frame_end & rx_s & ~par_err;
   assign load = keep & (~rx_valid_o | rx_ready_i);
   assign ovr  = keep & rx_valid_o & ~rx_ready_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state         <= IDLE;
         cnt           <= 16'd0;
         sh            <= 8'h00;
         idx           <= 3'd0;
         par_acc       <= 1'b0;
         par_err       <= 1'b0;
         rx_data_o     <= 8'h00;
         rx_valid_o    <= 1'b0;
         err_parity_o  <= 1'b0;
         err_frame_o   <= 1'b0;
         err_overrun_o <= 1'b0;
      end else begin
         err_frame_o   <= frame_end & ~rx_s;
         err_parity_o  <= frame_end & rx_s & par_err;
         err_overrun_o <= ovr;

         if (load) begin
            rx_data_o  <= sh >> cfg_bits_i;
            rx_valid_o <= 1'b1;
         end else if (rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end

         if (!cfg_en_i) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            sh      <= 8'h00;
            idx     <= 3'd0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
         end else begin
            if (state == IDLE || sample)
               cnt <= 16'd0;
            else
               cnt <= cnt + 16'd1;

            unique case (state)
               IDLE: begin
                  sh      <= 8'h00;
                  idx     <= 3'd0;
                  par_acc <= 1'b0;
                  par_err <= 1'b0;
                  if (!rx_s)
                     state <= START_BIT;
               end
               START_BIT: begin
                  if (sample)
                     state <= rx_s ? IDLE : DATA;
               end
               DATA: begin
                  if (sample) begin
                     sh      <= {rx_s, sh[7:1]};
                     par_acc <= par_acc ^ rx_s;
                     if (idx == last_bit(cfg_bits_i))
                        state <= cfg_parity_en_i ? PARITY
                                                 : STOP_BIT_FIRST;
                     else
                        idx <= idx + 3'd1;
                  end
               end
               PARITY: begin
                  if (sample) begin
                     par_err <= rx_s !=
                        par_exp(cfg_parity_sel_i, par_acc);
                     state   <= STOP_BIT_FIRST;
                  end
               end
               STOP_BIT_FIRST: begin
                  if (sample)
                     state <= (cfg_stop_bits_i && rx_s) ? STOP_BIT_LAST
                                                        : IDLE;
               end
               STOP_BIT_LAST: begin
                  if (sample)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, parity, errors, overrun,
// handshake, abort and a gapless 256-byte stream.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        rx = 1'b1;
   logic        en = 1'b0;
   logic [15:0] div = 16'd15;
   logic        pen = 1'b0;
   logic [1:0]  psel = 2'b00;
   logic [1:0]  bits = 2'b00;
   logic        stop2 = 1'b0;
   logic        rdy = 1'b0;
   logic [7:0]  rdata;
   logic        rvalid;
   logic        busy;
   logic        eperr;
   logic        eferr;
   logic        eovr;

   uart_rx dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .rx_i             (rx),
      .cfg_en_i         (en),
      .cfg_div_i        (div),
      .cfg_parity_en_i  (pen),
      .cfg_parity_sel_i (psel),
      .cfg_bits_i       (bits),
      .cfg_stop_bits_i  (stop2),
      .rx_data_o        (rdata),
      .rx_valid_o       (rvalid),
      .rx_ready_i       (rdy),
      .busy_o           (busy),
      .err_parity_o     (eperr),
      .err_frame_o      (eferr),
      .err_overrun_o    (eovr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_perr = 0;
   int         n_ferr = 0;
   int         n_ovr = 0;
   int         rise_cyc = 0;
   logic       vq = 1'b0;
   logic       collect = 1'b0;
   logic [7:0] q[$];

   always @(negedge clk) begin
      if (eperr) n_perr++;
      if (eferr) n_ferr++;
      if (eovr) n_ovr++;
      if (rvalid && !vq) rise_cyc = cyc;
      vq = rvalid;
      if (collect && rvalid && rdy) q.push_back(rdata);
   end

   int ncmp = 0;
   int nbad = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_out(input logic b);
      rx = b;
      repeat (int'(div) + 1) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input int nb,
                       input logic pe, input logic pb,
                       input logic s1, input logic s2,
                       input logic two);
      bit_out(1'b0);
      for (int i = 0; i < nb; i++) bit_out(d[i]);
      if (pe) bit_out(pb);
      bit_out(s1);
      if (two) bit_out(s2);
      rx = 1'b1;
   endtask

   task automatic drain();
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
   endtask

   int t0;
   int sp, sf, so;
   logic [7:0] bv;

   initial begin
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", rdata, 8'h00);
      chk("rst_valid", rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_perr", eperr, 0);
      chk("rst_ferr", eferr, 0);
      chk("rst_ovr", eovr, 0);
      rstn = 1'b1;
      en = 1'b1;
      repeat (4) @(negedge clk);

      // 8N1, div 15
      sp = n_perr; sf = n_ferr; so = n_ovr;
      t0 = cyc;
      send(8'hA5, 8, 0, 0, 1, 1, 0);
      chk("a5_latency", rise_cyc - t0, 155);
      chk("a5_data", rdata, 8'hA5);
      chk("a5_valid", rvalid, 1);
      chk("a5_errs", (n_perr - sp) + (n_ferr - sf) + (n_ovr - so), 0);
      drain();
      chk("a5_drained", rvalid, 0);

      // 7E1
      bits = 2'b01; pen = 1'b1; psel = 2'b01;
      send(8'h55, 7, 1, 0, 1, 1, 0);
      chk("7e1_data", rdata, 8'h55);
      chk("7e1_valid", rvalid, 1);
      drain();
      sp = n_perr;
      send(8'h55, 7, 1, 1, 1, 1, 0);
      chk("7e1_perr", n_perr - sp, 1);
      chk("7e1_bad_valid", rvalid, 0);

      // 5 bits, 2 stop, second stop low
      bits = 2'b11; pen = 1'b0; stop2 = 1'b1;
      sp = n_perr; sf = n_ferr;
      send(8'h15, 5, 0, 0, 1, 0, 1);
      repeat (20) @(negedge clk);
      chk("frm_ferr", n_ferr - sf, 1);
      chk("frm_no_perr", n_perr - sp, 0);
      chk("frm_valid", rvalid, 0);
      chk("frm_idle", busy, 0);

      // 3-cycle glitch
      bits = 2'b00; stop2 = 1'b0;
      sp = n_perr; sf = n_ferr; so = n_ovr;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_busy", busy, 1);
      repeat (20) @(negedge clk);
      chk("glitch_idle", busy, 0);
      chk("glitch_errs", (n_perr - sp) + (n_ferr - sf) + (n_ovr - so), 0);
      chk("glitch_valid", rvalid, 0);

      // overrun
      send(8'h11, 8, 0, 0, 1, 1, 0);
      chk("ovr_first", rdata, 8'h11);
      so = n_ovr;
      send(8'h22, 8, 0, 0, 1, 1, 0);
      chk("ovr_pulse", n_ovr - so, 1);
      chk("ovr_held", rdata, 8'h11);
      chk("ovr_valid", rvalid, 1);

      // accept in the load cycle of 33
      so = n_ovr;
      fork
         send(8'h33, 8, 0, 0, 1, 1, 0);
         begin
            repeat (154) @(negedge clk);
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
         end
      join
      chk("ld_acc_valid", rvalid, 1);
      chk("ld_acc_data", rdata, 8'h33);
      chk("ld_acc_no_ovr", n_ovr - so, 0);

      // abort mid-DATA
      sp = n_perr; sf = n_ferr; so = n_ovr;
      bit_out(1'b0);
      bit_out(1'b0);
      bit_out(1'b0);
      bit_out(1'b1);
      en = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      repeat (40) @(negedge clk);
      chk("abort_data", rdata, 8'h33);
      chk("abort_valid", rvalid, 1);
      chk("abort_errs", (n_perr - sp) + (n_ferr - sf) + (n_ovr - so), 0);
      en = 1'b1;
      drain();
      send(8'h3C, 8, 0, 0, 1, 1, 0);
      chk("reen_data", rdata, 8'h3C);
      chk("reen_valid", rvalid, 1);
      drain();

      // 8O2, div 3, gapless stream
      div = 16'd3; pen = 1'b1; psel = 2'b00; stop2 = 1'b1;
      sp = n_perr; sf = n_ferr; so = n_ovr;
      rdy = 1'b1;
      collect = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         bv = 8'(i);
         send(bv, 8, 1, ~^bv, 1, 1, 1);
      end
      repeat (10) @(negedge clk);
      collect = 1'b0;
      rdy = 1'b0;
      chk("b2b_count", q.size(), 256);
      for (int i = 0; i < q.size(); i++) begin
         chk($sformatf("b2b_%0d", i), q[i], i);
      end
      chk("b2b_perr", n_perr - sp, 0);
      chk("b2b_ferr", n_ferr - sf, 0);
      chk("b2b_ovr", n_ovr - so, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nbad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the APB UART peripheral. It accepts the same frame format that the UART transmitter produces: one start bit, 5–8 data bits sent LSB first, an optional parity bit, and 1 or 2 stop bits. It uses the shared divider and frame configuration registers. A received byte goes into a one-entry holding register, which the APB register block drains through a valid/ready handshake. Parity, framing and overrun errors are reported as single-cycle pulses.

## Interface
Parameters:
- none. Widths are fixed to match the transmitter.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous reset, active low.
- rx_i  in  1  serial line input, asynchronous to clk_i; idle level is 1.
- cfg_en_i  in  1  receiver enable. When 0, the FSM is forced to IDLE.
- cfg_div_i  in  16  bit period in clock cycles, minus 1.
- cfg_parity_en_i  in  1  a parity bit follows the data bits.
- cfg_parity_sel_i  in  2  00 odd (expected = ~^data), 01 even (^data), 10 forced 0, 11 forced 1.
- cfg_bits_i  in  2  00 = 8, 01 = 7, 10 = 6, 11 = 5 data bits.
- cfg_stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits.
- rx_data_o  out  8  received byte, right-justified; unused upper bits are 0. Reset value 8'h00.
- rx_valid_o  out  1  holding register is full. Reset value 0.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- busy_o  out  1  FSM is not in IDLE. Reset value 0.
- err_parity_o, err_frame_o, err_overrun_o  out  1 each  one-cycle error pulses. Reset value 0.

## Operation
Input synchronisation:
- rx_i passes through a 2-flop synchroniser. Both flops reset to 1.
- All logic below uses the synchronised value, rx_s.

FSM states: IDLE, START_BIT, DATA, PARITY, STOP_BIT_FIRST, STOP_BIT_LAST.

Baud counter:
- 16 bits, cleared whenever the FSM is in IDLE.
- A "sample" event occurs when the counter equals its target. The counter then restarts from 0.

State behaviour:
- IDLE: when rx_s == 0 and cfg_en_i == 1, go to START_BIT. The sample target is cfg_div_i >> 1 (half a bit period).
- START_BIT: at the sample, rx_s == 1 is a false start; return to IDLE with no error. rx_s == 0 goes to DATA. From here on the sample target is cfg_div_i (full bit period, cfg_div_i+1 cycles).
- DATA: at each sample, shift rx_s into the MSB of an 8-bit shift register. After the last data bit, go to PARITY if cfg_parity_en_i is set, otherwise to STOP_BIT_FIRST.
- Data alignment: the shift register is right-aligned by (8 − N) at capture.
- Parity: a running XOR of the data bits is kept.
- PARITY: sample rx_s and compare it with the expected value from cfg_parity_sel_i. Record a mismatch.
- STOP_BIT_FIRST: sample the stop bit. If rx_s == 0, record a frame error. Then:
  - if cfg_stop_bits_i is set and the bit was 1, go to STOP_BIT_LAST;
  - otherwise end the frame.
- STOP_BIT_LAST: sample the second stop bit; 0 is a frame error. End the frame.

End of frame (same cycle as the final sample; FSM returns to IDLE):
- Frame error: pulse err_frame_o and discard the byte. Frame error takes precedence over parity error.
- Else parity error: pulse err_parity_o and discard the byte.
- Else, if rx_valid_o == 0 or rx_ready_i == 1: load rx_data_o and set rx_valid_o.
- Else: discard the new byte and pulse err_overrun_o. The held byte is unchanged.

Handshake:
- rx_valid_o && rx_ready_i in a cycle with no load clears rx_valid_o.
- A load and an accept in the same cycle leave rx_valid_o at 1 with the new data.

cfg_en_i deassertion:
- FSM goes to IDLE on the next edge; the counter and shift register are cleared.
- The holding register and rx_valid_o are kept.
- No error pulses are raised.

Configuration inputs are assumed stable while busy_o == 1. Changing them mid-frame gives undefined data but must not lock up the FSM.

## Timing
- From an rx_i falling edge to the START_BIT entry: 3 cycles (2 synchroniser cycles + 1 FSM cycle).
- Start bit sample: (cfg_div_i >> 1) + 1 cycles after entering START_BIT.
- Every later sample: cfg_div_i + 1 cycles after the previous one.
- rx_valid_o and the error pulses are registered. They rise on the edge after the final stop sample.
- The FSM is in IDLE that same cycle, so a new start bit is detected immediately. Back-to-back frames with no idle gap must be received.
- Minimum supported cfg_div_i is 3.
- Reset mid-frame: all state returns to reset values asynchronously, with no pulses.

## Structure
- Shared package, common with the transmitter:
  - FSM state encoding (3-bit localparams);
  - cfg_bits_i decode to the last data bit index (3'h7..3'h4);
  - parity_sel encodings.
- Natural sub-module: uart_rx_sync, a 2-flop synchroniser with reset value 1. It is reusable for other pad inputs.
- Everything else sits flat in uart_rx: FSM, baud counter, shift register, parity accumulator, holding register.

## Test plan
- Basic frame: cfg_div_i=15, 8N1, send 8'hA5 → rx_data_o=8'hA5 and rx_valid_o=1 exactly one cycle after the stop sample; no errors.
- Parity: 7E1 with sel=01, send 7'h55 with a correct parity bit → data 8'h55. Repeat with the parity bit flipped → err_parity_o pulse, rx_valid_o stays 0.
- Framing and false start:
  - 5-bit, 2 stop bits, second stop driven 0 → err_frame_o pulse, no data.
  - A 3-cycle low glitch on rx_i in IDLE → FSM returns to IDLE, no pulses.
- Overrun:
  - Receive 8'h11 with rx_ready_i=0, then 8'h22 → err_overrun_o pulse, rx_data_o stays 8'h11.
  - Assert rx_ready_i in the load cycle of 8'h33 → rx_valid_o stays 1 and rx_data_o=8'h33.
- Back-to-back: loop the transmitter to the receiver, 8O2, cfg_div_i=3, stream 256 bytes 0..255 with no gaps → all received in order, zero errors.
- Abort: deassert cfg_en_i mid-DATA → busy_o=0 next cycle, held byte unchanged. Re-enable and send 8'h3C → received correctly.
